// File: rtl/knn_vote.sv
// knn_vote: k-nearest-neighbour majority vote over one sorted distance vector.
// Ports:
//   clk, rst (async active-low)
//   in_valid, ascending, in, in_type     -> vector from the distance sorter
//   in_ready (high in IDLE only)
//   out_valid, out_class, out_votes, out_min_dist -> registered decision
//   overrun (sticky: in_valid seen while busy)
module knn_vote #(
  parameter int L      = 4,
  parameter int W      = 16,
  parameter int TYPE_W = 3,
  parameter int K      = 5,
  localparam int N     = 1 << L,
  localparam int C     = 1 << TYPE_W,
  localparam int VW    = $clog2(K + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                ascending,
  input  logic [W*N-1:0]      in,
  input  logic [TYPE_W*N-1:0] in_type,
  output logic                in_ready,
  output logic                out_valid,
  output logic [TYPE_W-1:0]   out_class,
  output logic [VW-1:0]       out_votes,
  output logic [W-1:0]        out_min_dist,
  output logic                overrun
);
  if (K < 1 || K > N) begin : g_bad_k
    $error("knn_vote: K must satisfy 1 <= K <= N");
  end
  localparam logic [1:0] IDLE = 2'd0, COUNT = 2'd1, ARGMAX = 2'd2, DONE = 2'd3;
  logic [1:0]                 state_q;
  logic                       asc_q;
  logic [W*N-1:0]             dist_q;
  logic [TYPE_W*N-1:0]        type_q;
  logic [L-1:0]               rank_q;
  logic [TYPE_W-1:0]          cls_q;
  logic [C-1:0][VW-1:0]       votes_q;
  logic [C-1:0][L-1:0]        first_q;
  logic [VW-1:0]              best_votes_q;
  logic [L-1:0]               best_rank_q;
  logic [TYPE_W-1:0]          best_class_q;
  logic [W-1:0]               min_q;
  logic                       out_valid_q;
  logic [TYPE_W-1:0]          out_class_q;
  logic [VW-1:0]              out_votes_q;
  logic [W-1:0]               out_min_q;
  logic                       overrun_q;
  logic [L-1:0]               idx;
  logic [TYPE_W-1:0]          lbl;
  logic [W-1:0]               dist_r;
  logic [VW-1:0]              vc;
  logic                       take;
  // descending vectors hold the nearest entry at N-1, and N-1-r == ~r in L bits
  always_comb begin
    idx    = asc_q ? rank_q : ~rank_q;
    lbl    = type_q[TYPE_W*idx +: TYPE_W];
    dist_r = dist_q[W*idx +: W];
    vc     = votes_q[cls_q];
    take   = (vc > best_votes_q) ||
             (vc == best_votes_q && vc != '0 && first_q[cls_q] < best_rank_q);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      asc_q        <= 1'b0;
      dist_q       <= '0;
      type_q       <= '0;
      rank_q       <= '0;
      cls_q        <= '0;
      votes_q      <= '0;
      first_q      <= '0;
      best_votes_q <= '0;
      best_rank_q  <= '0;
      best_class_q <= '0;
      min_q        <= '0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_votes_q  <= '0;
      out_min_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (in_valid && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (in_valid) begin
          dist_q  <= in;
          type_q  <= in_type;
          asc_q   <= ascending;
          votes_q <= '0;
          first_q <= '1;
          rank_q  <= '0;
          state_q <= COUNT;
        end
        COUNT: begin
          votes_q[lbl] <= votes_q[lbl] + VW'(1);
          if (&first_q[lbl]) first_q[lbl] <= rank_q;
          if (rank_q == '0) min_q <= dist_r;
          rank_q <= rank_q + L'(1);
          if (rank_q == L'(K - 1)) begin
            state_q      <= ARGMAX;
            cls_q        <= '0;
            best_votes_q <= '0;
            best_rank_q  <= '1;
            best_class_q <= '0;
          end
        end
        ARGMAX: begin
          if (take) begin
            best_votes_q <= vc;
            best_rank_q  <= first_q[cls_q];
            best_class_q <= cls_q;
          end
          cls_q <= cls_q + TYPE_W'(1);
          if (&cls_q) state_q <= DONE;
        end
        default: begin
          out_class_q <= best_class_q;
          out_votes_q <= best_votes_q;
          out_min_q   <= min_q;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end
  assign in_ready     = state_q == IDLE;
  assign out_valid    = out_valid_q;
  assign out_class    = out_class_q;
  assign out_votes    = out_votes_q;
  assign out_min_dist = out_min_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed table-driven bench for knn_vote with default parameters.
module tb_knn_vote;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         ascending;
  logic [255:0] in;
  logic [47:0]  in_type;
  logic         in_ready;
  logic         out_valid;
  logic [2:0]   out_class;
  logic [2:0]   out_votes;
  logic [15:0]  out_min_dist;
  logic         overrun;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic         asc;
    logic [255:0] d;
    logic [47:0]  t;
    logic [2:0]   c;
    logic [2:0]   v;
    logic [15:0]  m;
  } vec_t;
  vec_t tv[6];
  knn_vote dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ascending(ascending),
    .in(in), .in_type(in_type), .in_ready(in_ready), .out_valid(out_valid),
    .out_class(out_class), .out_votes(out_votes), .out_min_dist(out_min_dist),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic asc, input int d0, input int ds,
                              input int l0, input int l1, input int l2, input int l3,
                              input int l4, input int fill, input int c, input int v);
    vec_t x;
    int lab[5];
    int e;
    lab = '{l0, l1, l2, l3, l4};
    x.asc = asc;
    x.d = '0;
    x.t = '0;
    for (int r = 0; r < 16; r++) begin
      e = asc ? r : 15 - r;
      x.d[16*e +: 16] = 16'(d0 + ds * r);
      x.t[3*e +: 3]   = 3'(r < 5 ? lab[r] : fill);
    end
    x.c = 3'(c);
    x.v = 3'(v);
    x.m = 16'(d0);
    return x;
  endfunction
  task automatic drive(input vec_t x);
    in_valid  = 1'b1;
    ascending = x.asc;
    in        = x.d;
    in_type   = x.t;
  endtask
  task automatic wait_out(input string name, output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin n = k; break; end
    end
    chk({name, "_latency"}, n, 14);
  endtask
  task automatic chk_res(input string name, input vec_t x);
    chk({name, "_class"}, out_class, x.c);
    chk({name, "_votes"}, out_votes, x.v);
    chk({name, "_min"}, out_min_dist, x.m);
    chk({name, "_ready"}, in_ready, 1'b1);
  endtask
  task automatic run_vec(input string name, input vec_t x);
    int n;
    drive(x);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_busy"}, in_ready, 1'b0);
    wait_out(name, n);
    chk_res(name, x);
  endtask
  initial begin
    int n;
    tv[0] = mk(1'b1, 0, 1, 2, 3, 2, 5, 2, 0, 2, 3);
    tv[1] = mk(1'b0, 7, 3, 6, 6, 1, 6, 1, 3, 6, 3);
    tv[2] = mk(1'b1, 1, 3, 4, 1, 1, 4, 0, 2, 4, 2);
    tv[3] = mk(1'b1, 1000, 1, 7, 7, 7, 7, 7, 7, 7, 5);
    tv[4] = mk(1'b0, 20, 2, 0, 5, 5, 0, 3, 5, 0, 2);
    tv[5] = mk(1'b1, 9, 1, 3, 1, 4, 6, 2, 1, 3, 1);
    rst = 1'b0;
    in_valid = 1'b0;
    ascending = 1'b0;
    in = '0;
    in_type = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_class", out_class, 3'd0);
    chk("rst_votes", out_votes, 3'd0);
    chk("rst_min", out_min_dist, 16'd0);
    chk("rst_overrun", overrun, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), tv[i]);
      @(posedge clk); #1;
    end
    chk("no_overrun_yet", overrun, 1'b0);
    drive(tv[0]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drive(tv[2]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ovr_flag", overrun, 1'b1);
    for (int k = 4; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin n = k; break; end
    end
    chk("ovr_latency", n, 14);
    chk_res("ovr_first", tv[0]);
    drive(tv[2]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ovr_accept_busy", in_ready, 1'b0);
    wait_out("ovr_second", n);
    chk_res("ovr_second", tv[2]);
    chk("ovr_sticky", overrun, 1'b1);
    @(posedge clk); #1;
    drive(tv[3]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_class", out_class, 3'd0);
    chk("mid_rst_votes", out_votes, 3'd0);
    chk("mid_rst_min", out_min_dist, 16'd0);
    chk("mid_rst_overrun", overrun, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("mid_rst_no_result", n, 0);
    chk("mid_rst_ready_after", in_ready, 1'b1);
    run_vec("post_rst", tv[1]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/knn_vote.md
# knn_vote

Majority-vote classifier that consumes one sorted distance vector and its type labels from the distance sorter and produces the k-nearest-neighbour decision. It captures the vector on the sorter's `out_valid` pulse and walks the K nearest entries one per cycle, accumulating per-class vote counts. It then scans the classes to pick the winner, breaking ties by nearest neighbour. It sits directly after the distance sort stage and drives the classification result.

## Interface
- `L`, default 4: log2 of the vector length; N = 1<<L entries.
- `W`, default 16: width of one distance entry.
- `TYPE_W`, default 3: class label width; C = 1<<TYPE_W classes.
- `K`, default 5: number of neighbours voted; legal range 1 <= K <= N; out-of-range values are a compile-time error.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: one-cycle pulse; `in`/`in_type` are valid (sorter `out_valid`).
- `ascending`, input, 1: sort order of the presented vector, sampled together with `in_valid`.
- `in`, input, W*N: sorted distances; entry i is `in[W*i +: W]`.
- `in_type`, input, TYPE_W*N: labels; entry i is `in_type[TYPE_W*i +: TYPE_W]`.
- `in_ready`, output, 1: high only in IDLE; the block accepts a vector only while it is high.
- `out_valid`, output, 1: one-cycle pulse when the result is updated.
- `out_class`, output, TYPE_W: winning class.
- `out_votes`, output, clog2(K+1): vote count of the winning class.
- `out_min_dist`, output, W: distance of the nearest (rank-0) entry.
- `overrun`, output, 1: sticky flag; set when `in_valid` arrives while `in_ready` is low. Cleared only by reset.

## Operation
- **Rank mapping:** rank r maps to entry r when `ascending`=1, and to entry N-1-r when `ascending`=0.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`, capture `in`, `in_type` and `ascending`.
  - Clear all C vote counters and set every `first_rank` to all-ones.
  - Go to COUNT with rank counter = 0.
- **COUNT:** runs K cycles; each cycle processes one rank r.
  - Increment the vote counter of t = label(r).
  - If `first_rank[t]` is all-ones, set `first_rank[t]` = r.
  - Latch `out_min_dist` candidate at r = 0.
  - After r = K-1, go to ARGMAX.
- **ARGMAX:** runs C cycles, scanning class c = 0..C-1.
  - Initial best: votes = 0, rank = all-ones, class = 0.
  - Replace the best if votes[c] > best_votes.
  - Also replace if votes[c] == best_votes, votes[c] != 0 and `first_rank[c]` < best_rank.
  - Classes with zero votes never win.
  - After c = C-1, go to DONE.
- **DONE:** runs 1 cycle.
  - Register `out_class`, `out_votes` and `out_min_dist`; pulse `out_valid`.
  - Return to IDLE.
- **Held results:** outputs hold their values until the next DONE.
- **Overrun:** `in_valid` outside IDLE is dropped (no state change) and sets `overrun`.
- **Arithmetic:**
  - Vote counters are clog2(K+1) bits wide and cannot overflow, since the total is K.
  - Rank registers are L bits; all-ones serves as the "unset" sentinel. Rank N-1 equals that value, but it is never the unique tie-break winner, because a smaller rank always wins first.

## Timing
- **Reset values:**
  - State = IDLE, `in_ready`=1, `out_valid`=0, `overrun`=0.
  - `out_class`=0, `out_votes`=0, `out_min_dist`=0.
  - All counters = 0.
- **Latency:**
  - Accept edge = edge 0.
  - COUNT occupies edges 1..K, ARGMAX edges K+1..K+C, DONE edge K+C+1.
  - `out_valid` is high during the cycle after edge K+C+1.
  - With defaults that is 14 cycles after acceptance.
- **Ready timing:** `in_ready` falls in the cycle after acceptance and rises together with `out_valid`. A new `in_valid` in the `out_valid` cycle is accepted.
- **Throughput:** one vector per K+C+2 cycles.
- **Reset mid-operation:** asynchronous return to reset values. A partial result is never emitted.
- **Simultaneous events:** `in_valid` coinciding with the DONE edge is dropped and flags `overrun`.

## Test plan
All scenarios use defaults (L=4, W=16, TYPE_W=3, K=5).
- **Ascending majority:** ascending=1, distances 0..15, labels of ranks 0..4 = 2,3,2,5,2 -> `out_valid` 14 cycles after accept, `out_class`=2, `out_votes`=3, `out_min_dist`=0.
- **Descending:** ascending=0, entry 15 = distance 7 label 6, entries 14..11 labels 6,1,6,1 -> `out_class`=6, `out_votes`=3, `out_min_dist`=7.
- **Tie-break:** ranks 0..4 labels 4,1,1,4,0 -> classes 1 and 4 tied at 2 votes; class 4 (first_rank 0) wins, `out_class`=4, `out_votes`=2.
- **All-same label:** every label 7 -> `out_class`=7, `out_votes`=5; classes 0..6 with zero votes never selected.
- **Overrun:** second `in_valid` 3 cycles after the first -> dropped, `overrun`=1 sticky, first result unchanged; `in_valid` in the `out_valid` cycle -> accepted, second result 14 cycles later.
- **Reset:** `rst` asserted low mid-COUNT -> all outputs at reset values immediately, no `out_valid`, `in_ready`=1 after release.
